// File: rtl/lenet_pkg.sv
// Shared LeNet weight-loading definitions: loader states, layer IDs and the
// per-layer memory map used by the weight loader and the sequencing controller.
package lenet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_FETCH_W      = 3'd1,
        ST_FETCH_B      = 3'd2,
        ST_DRAIN        = 3'd3,
        ST_DONE         = 3'd4,
        ST_WAIT_RELEASE = 3'd5
    } state_e;

    localparam logic [3:0] LAYER_ID_1 = 4'd1;
    localparam logic [3:0] LAYER_ID_2 = 4'd2;
    localparam logic [3:0] LAYER_ID_3 = 4'd3;
    localparam logic [3:0] LAYER_ID_4 = 4'd4;

    localparam int W_CNT_W = 10;
    localparam int B_CNT_W = 5;

    localparam logic [15:0] L1_WBASE = 16'h0000;
    localparam logic [9:0]  L1_NW    = 10'd150;
    localparam logic [15:0] L1_BBASE = 16'h0100;
    localparam logic [2:0]  L1_NB    = 3'd6;

    localparam logic [15:0] L2_WBASE = 16'h0200;
    localparam logic [9:0]  L2_NW    = 10'd900;
    localparam logic [15:0] L2_BBASE = 16'h0600;
    localparam logic [2:0]  L2_NB    = 3'd6;

    localparam logic [15:0] L3_WBASE = 16'h0700;
    localparam logic [9:0]  L3_NW    = 10'd900;
    localparam logic [15:0] L3_BBASE = 16'h0B00;
    localparam logic [2:0]  L3_NB    = 3'd6;

    localparam logic [15:0] L4_WBASE = 16'h0C00;
    localparam logic [9:0]  L4_NW    = 10'd600;
    localparam logic [15:0] L4_BBASE = 16'h0F00;
    localparam logic [2:0]  L4_NB    = 3'd4;

    typedef struct packed {
        logic        valid;
        logic [15:0] wbase;
        logic [9:0]  nw;
        logic [15:0] bbase;
        logic [2:0]  nb;
    } layer_cfg_t;

    function automatic logic layer_id_valid(input logic [3:0] id);
        return (id == LAYER_ID_1) || (id == LAYER_ID_2) ||
               (id == LAYER_ID_3) || (id == LAYER_ID_4);
    endfunction

    // An unknown ID yields an all-zero entry with valid cleared.
    function automatic layer_cfg_t layer_lookup(input logic [3:0] id);
        layer_cfg_t cfg;
        case (id)
            LAYER_ID_1: cfg = '{valid: 1'b1, wbase: L1_WBASE, nw: L1_NW, bbase: L1_BBASE, nb: L1_NB};
            LAYER_ID_2: cfg = '{valid: 1'b1, wbase: L2_WBASE, nw: L2_NW, bbase: L2_BBASE, nb: L2_NB};
            LAYER_ID_3: cfg = '{valid: 1'b1, wbase: L3_WBASE, nw: L3_NW, bbase: L3_BBASE, nb: L3_NB};
            LAYER_ID_4: cfg = '{valid: 1'b1, wbase: L4_WBASE, nw: L4_NW, bbase: L4_BBASE, nb: L4_NB};
            default:    cfg = '0;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/lenet_weight_loader_if.sv
// Signal bundle for the weight loader: request/ack handshake, weight-memory read
// port and weight-buffer / bias-register write ports, with loader and host views.
interface lenet_weight_loader_if #(
    parameter int WMEM_AW = 16,
    parameter int WBUF_AW = 10
);
    logic               req_load_weight;
    logic [3:0]         layer_id;
    logic               weight_loaded;
    logic               err_layer;
    logic               wmem_rd_en;
    logic [WMEM_AW-1:0] wmem_addr;
    logic [7:0]         wmem_rdata;
    logic               wbuf_we;
    logic [WBUF_AW-1:0] wbuf_addr;
    logic [7:0]         wbuf_wdata;
    logic               bias_we;
    logic [2:0]         bias_addr;
    logic [31:0]        bias_wdata;

    modport master (
        input  req_load_weight, layer_id, wmem_rdata,
        output weight_loaded, err_layer, wmem_rd_en, wmem_addr,
               wbuf_we, wbuf_addr, wbuf_wdata, bias_we, bias_addr, bias_wdata
    );

    modport slave (
        output req_load_weight, layer_id, wmem_rdata,
        input  weight_loaded, err_layer, wmem_rd_en, wmem_addr,
               wbuf_we, wbuf_addr, wbuf_wdata, bias_we, bias_addr, bias_wdata
    );
endinterface

// File: rtl/lenet_weight_loader.sv
// Streams one layer's weights and biases from byte-wide weight memory into the
// weight buffer and bias registers, with a one-cycle-latency read pipeline.
module lenet_weight_loader
    import lenet_pkg::*;
#(
    parameter int WMEM_AW = 16,
    parameter int WBUF_AW = 10
) (
    input  logic               clk_i,
    input  logic               rst_async_n_i,
    input  logic               req_load_weight_i,
    input  logic [3:0]         layer_id_i,
    output logic               weight_loaded_o,
    output logic               err_layer_o,
    output logic               wmem_rd_en_o,
    output logic [WMEM_AW-1:0] wmem_addr_o,
    input  logic [7:0]         wmem_rdata_i,
    output logic               wbuf_we_o,
    output logic [WBUF_AW-1:0] wbuf_addr_o,
    output logic [7:0]         wbuf_wdata_o,
    output logic               bias_we_o,
    output logic [2:0]         bias_addr_o,
    output logic [31:0]        bias_wdata_o
);

    state_e               state_q, state_d;
    logic [3:0]           id_q, id_d;
    logic [W_CNT_W-1:0]   w_cnt_q, w_cnt_d;
    logic [B_CNT_W-1:0]   b_cnt_q, b_cnt_d;
    logic                 rsp_w_q, rsp_w_d;
    logic                 rsp_b_q, rsp_b_d;
    logic [W_CNT_W-1:0]   rsp_idx_q, rsp_idx_d;
    logic [23:0]          bias_sr_q, bias_sr_d;

    layer_cfg_t           cfg;
    logic                 w_last;
    logic                 b_last;
    logic                 bias_word_done;

    assign cfg    = layer_lookup(id_q);
    assign w_last = (w_cnt_q == (cfg.nw - 10'd1));
    assign b_last = (b_cnt_q == B_CNT_W'({cfg.nb, 2'b00} - 5'd1));

    // NOTE: every signal driven here gets a default before the case so that no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        w_cnt_d      = w_cnt_q;
        b_cnt_d      = b_cnt_q;
        rsp_w_d      = 1'b0;
        rsp_b_d      = 1'b0;
        rsp_idx_d    = '0;
        wmem_rd_en_o = 1'b0;
        wmem_addr_o  = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_load_weight_i) begin
                    id_d    = layer_id_i;
                    w_cnt_d = '0;
                    b_cnt_d = '0;
                    state_d = layer_id_valid(layer_id_i) ? ST_FETCH_W : ST_DONE;
                end
            end
            ST_FETCH_W: begin
                wmem_rd_en_o = 1'b1;
                wmem_addr_o  = WMEM_AW'(cfg.wbase) + WMEM_AW'(w_cnt_q);
                rsp_w_d      = 1'b1;
                rsp_idx_d    = w_cnt_q;
                if (w_last) begin
                    state_d = ST_FETCH_B;
                end else begin
                    w_cnt_d = w_cnt_q + 10'd1;
                end
            end
            ST_FETCH_B: begin
                wmem_rd_en_o = 1'b1;
                wmem_addr_o  = WMEM_AW'(cfg.bbase) + WMEM_AW'(b_cnt_q);
                rsp_b_d      = 1'b1;
                rsp_idx_d    = W_CNT_W'(b_cnt_q);
                if (b_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    b_cnt_d = b_cnt_q + 5'd1;
                end
            end
            ST_DRAIN:        state_d = ST_DONE;
            ST_DONE:         state_d = ST_WAIT_RELEASE;
            ST_WAIT_RELEASE: if (!req_load_weight_i) state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Response side: data arriving this cycle belongs to last cycle's strobe.
    assign bias_word_done = rsp_b_q && (rsp_idx_q[1:0] == 2'b11);
    assign bias_sr_d      = rsp_b_q ? {wmem_rdata_i, bias_sr_q[23:8]} : bias_sr_q;

    assign wbuf_we_o    = rsp_w_q;
    assign wbuf_addr_o  = rsp_w_q ? WBUF_AW'(rsp_idx_q) : '0;
    assign wbuf_wdata_o = rsp_w_q ? wmem_rdata_i : 8'h00;

    // Little-endian: the shift register holds bytes 0..2, the 4th byte is on the bus.
    assign bias_we_o    = bias_word_done;
    assign bias_addr_o  = bias_word_done ? rsp_idx_q[4:2] : 3'd0;
    assign bias_wdata_o = bias_word_done ? {wmem_rdata_i, bias_sr_q} : 32'h0;

    assign weight_loaded_o = (state_q == ST_DONE);
    assign err_layer_o     = (state_q == ST_DONE) && !cfg.valid;

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; all flops, including the bias shift register, reset so
    // an abandoned load leaves nothing behind.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            w_cnt_q   <= '0;
            b_cnt_q   <= '0;
            rsp_w_q   <= 1'b0;
            rsp_b_q   <= 1'b0;
            rsp_idx_q <= '0;
            bias_sr_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            w_cnt_q   <= w_cnt_d;
            b_cnt_q   <= b_cnt_d;
            rsp_w_q   <= rsp_w_d;
            rsp_b_q   <= rsp_b_d;
            rsp_idx_q <= rsp_idx_d;
            bias_sr_q <= bias_sr_d;
        end
    end

endmodule

// File: tb/tb_lenet_weight_loader.sv
// Self-checking bench for lenet_weight_loader: a cycle-timeline reference model
// predicts every output each cycle; directed and random loads pin the model.
module tb_lenet_weight_loader;

    localparam int WMEM_AW = 16;
    localparam int WBUF_AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lenet_weight_loader_if #(.WMEM_AW(WMEM_AW), .WBUF_AW(WBUF_AW)) bus ();

    lenet_weight_loader #(.WMEM_AW(WMEM_AW), .WBUF_AW(WBUF_AW)) dut (
        .clk_i             (clk),
        .rst_async_n_i     (rst_n),
        .req_load_weight_i (bus.req_load_weight),
        .layer_id_i        (bus.layer_id),
        .weight_loaded_o   (bus.weight_loaded),
        .err_layer_o       (bus.err_layer),
        .wmem_rd_en_o      (bus.wmem_rd_en),
        .wmem_addr_o       (bus.wmem_addr),
        .wmem_rdata_i      (bus.wmem_rdata),
        .wbuf_we_o         (bus.wbuf_we),
        .wbuf_addr_o       (bus.wbuf_addr),
        .wbuf_wdata_o      (bus.wbuf_wdata),
        .bias_we_o         (bus.bias_we),
        .bias_addr_o       (bus.bias_addr),
        .bias_wdata_o      (bus.bias_wdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [7:0] mem [65536];

    // Reference layer table.
    function automatic void ref_layer(input int id, output bit ok, output int wb,
                                      output int nw, output int bb, output int nb);
        ok = 1'b1;
        case (id)
            1: begin wb = 'h0000; nw = 150; bb = 'h0100; nb = 6; end
            2: begin wb = 'h0200; nw = 900; bb = 'h0600; nb = 6; end
            3: begin wb = 'h0700; nw = 900; bb = 'h0B00; nb = 6; end
            4: begin wb = 'h0C00; nw = 600; bb = 'h0F00; nb = 4; end
            default: begin ok = 1'b0; wb = 0; nw = 0; bb = 0; nb = 0; end
        endcase
    endfunction

    function automatic int ref_latency(input int id);
        bit ok;
        int wb, nw, bb, nb;
        ref_layer(id, ok, wb, nw, bb, nb);
        return ok ? nw + 4 * nb + 2 : 1;
    endfunction

    // Model: a load is a timeline of cycles 1..m_d after the sampling edge.
    bit m_loading = 1'b0;
    bit m_wait    = 1'b0;
    bit m_ok      = 1'b0;
    int m_cyc = 0, m_d = 0, m_wb = 0, m_nw = 0, m_bb = 0, m_nb = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_loading = 1'b0;
            m_wait    = 1'b0;
        end else if (m_loading) begin
            if (m_cyc == m_d) begin
                m_loading = 1'b0;
                m_wait    = 1'b1;
            end else begin
                m_cyc++;
            end
        end else if (m_wait) begin
            if (!bus.req_load_weight) m_wait = 1'b0;
        end else if (bus.req_load_weight) begin
            ref_layer(int'(bus.layer_id), m_ok, m_wb, m_nw, m_bb, m_nb);
            m_d       = m_ok ? m_nw + 4 * m_nb + 2 : 1;
            m_cyc     = 1;
            m_loading = 1'b1;
        end
    end

    function automatic logic [73:0] pack_out(input logic ack, err, rd, input logic [15:0] addr,
                                             input logic we, input logic [9:0] wa, input logic [7:0] wd,
                                             input logic bwe, input logic [2:0] ba, input logic [31:0] bd);
        return {ack, err, rd, addr, we, wa, wd, bwe, ba, bd};
    endfunction

    function automatic logic [73:0] model_out();
        logic ack = 0, err = 0, rd = 0, we = 0, bwe = 0;
        logic [15:0] addr = '0;
        logic [9:0]  wa = '0;
        logic [7:0]  wd = '0;
        logic [2:0]  ba = '0;
        logic [31:0] bd = '0;
        int n, j, l;
        if (rst_n && m_loading) begin
            n = m_cyc;
            if (!m_ok) begin
                ack = (n == 1);
                err = (n == 1);
            end else begin
                l = m_nw + 4 * m_nb;
                if (n >= 1 && n <= m_nw) begin
                    rd = 1; addr = 16'(m_wb + n - 1);
                end else if (n > m_nw && n <= l) begin
                    rd = 1; addr = 16'(m_bb + n - m_nw - 1);
                end
                if (n >= 2 && n <= m_nw + 1) begin
                    we = 1; wa = 10'(n - 2); wd = mem[16'(m_wb + n - 2)];
                end
                j = n - m_nw - 2;
                if (j >= 0 && j < 4 * m_nb && (j % 4) == 3) begin
                    bwe = 1;
                    ba  = 3'(j / 4);
                    bd  = {mem[16'(m_bb + j)], mem[16'(m_bb + j - 1)],
                           mem[16'(m_bb + j - 2)], mem[16'(m_bb + j - 3)]};
                end
                ack = (n == l + 2);
            end
        end
        return pack_out(ack, err, rd, addr, we, wa, wd, bwe, ba, bd);
    endfunction

    logic [73:0] dut_vec;
    assign dut_vec = {bus.weight_loaded, bus.err_layer, bus.wmem_rd_en, bus.wmem_addr,
                      bus.wbuf_we, bus.wbuf_addr, bus.wbuf_wdata,
                      bus.bias_we, bus.bias_addr, bus.bias_wdata};

    // Compare and monitor on the falling edge.
    int rd_cnt = 0, wr_cnt = 0, bias_cnt = 0, ack_cnt = 0, err_cnt = 0;
    logic [2:0]  last_baddr = '0;
    logic [7:0]  wlog [1024];
    logic [31:0] blog [8];

    initial forever begin
        @(negedge clk);
        check("cycle_outputs", 80'(dut_vec), 80'(model_out()));
        if (bus.wmem_rd_en) rd_cnt++;
        if (bus.wbuf_we) begin
            wr_cnt++;
            wlog[bus.wbuf_addr] = bus.wbuf_wdata;
        end
        if (bus.bias_we) begin
            bias_cnt++;
            blog[bus.bias_addr] = bus.bias_wdata;
            last_baddr = bus.bias_addr;
        end
        if (bus.weight_loaded) begin
            ack_cnt++;
            if (bus.err_layer) err_cnt++;
        end
    end

    // Weight memory: data for a strobe appears one cycle later.
    initial begin
        logic        pend;
        logic [15:0] pa;
        bus.wmem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            pend = bus.wmem_rd_en;
            pa   = bus.wmem_addr;
            @(posedge clk);
            #1;
            bus.wmem_rdata = pend ? mem[pa] : 8'($urandom);
        end
    end

    task automatic fill_lsb();
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
    endtask

    task automatic fill_random();
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    endtask

    task automatic run_load(input logic [3:0] id, input int exp_lat, input int drop_cyc,
                            input int hold_after, input string tag);
        int lat, r0, w0, b0, a0, e0;
        bit ok;
        int wb, nw, bb, nb;
        @(posedge clk);
        #1;
        r0 = rd_cnt; w0 = wr_cnt; b0 = bias_cnt; a0 = ack_cnt; e0 = err_cnt;
        bus.layer_id        = id;
        bus.req_load_weight = 1'b1;
        @(posedge clk);
        #1;
        bus.layer_id = 4'($urandom);
        lat = -1;
        for (int k = 1; k <= 1200; k++) begin
            @(negedge clk);
            if (k == drop_cyc) bus.req_load_weight = 1'b0;
            if (bus.weight_loaded === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 80'(lat), 80'(exp_lat));
        repeat (hold_after) @(negedge clk);
        bus.req_load_weight = 1'b0;
        @(negedge clk);
        #1;
        ref_layer(int'(id), ok, wb, nw, bb, nb);
        check({tag, "_reads"},  80'(rd_cnt - r0),   80'(nw + 4 * nb));
        check({tag, "_wwrites"}, 80'(wr_cnt - w0),  80'(nw));
        check({tag, "_bwrites"}, 80'(bias_cnt - b0), 80'(nb));
        check({tag, "_acks"},   80'(ack_cnt - a0),  80'(1));
        check({tag, "_errs"},   80'(err_cnt - e0),  80'(ok ? 0 : 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time budget expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0] rid;
        int rlat, rdrop;
        bus.req_load_weight = 1'b0;
        bus.layer_id        = 4'd0;
        fill_lsb();
        repeat (3) @(negedge clk);
        check("reset_outputs", 80'(dut_vec), 80'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ID1 held well past the ack: one load only.
        run_load(4'd1, 176, 0, 20, "id1_held");
        check("id1_bias0", 80'(blog[0]), 80'(32'h03020100));
        check("id1_bias5", 80'(blog[5]), 80'(32'h17161514));
        check("id1_w149",  80'(wlog[149]), 80'(8'h95));

        // Back-to-back IDs 2, 3, 4, each dropped one cycle after the ack.
        run_load(4'd2, 926, 0, 1, "id2");
        check("id2_last_baddr", 80'(last_baddr), 80'(3'd5));
        check("id2_w899", 80'(wlog[899]), 80'(8'h83));
        run_load(4'd3, 926, 0, 1, "id3");
        check("id3_last_baddr", 80'(last_baddr), 80'(3'd5));
        run_load(4'd4, 618, 0, 1, "id4");
        check("id4_last_baddr", 80'(last_baddr), 80'(3'd3));
        check("id4_bias3", 80'(blog[3]), 80'(32'h0F0E0D0C));

        // Invalid IDs.
        run_load(4'd0, 1, 0, 0, "id0");
        run_load(4'd7, 1, 0, 0, "id7");

        // Reset during an ID2 load, then a fresh load with the request still high.
        fill_random();
        @(posedge clk);
        #1;
        bus.layer_id        = 4'd2;
        bus.req_load_weight = 1'b1;
        @(posedge clk);
        #1;
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midload_reset_outputs", 80'(dut_vec), 80'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.layer_id = 4'($urandom);
        lat = -1;
        for (int k = 1; k <= 1200; k++) begin
            @(negedge clk);
            if (bus.weight_loaded === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("post_reset_latency", 80'(lat), 80'(926));
        bus.req_load_weight = 1'b0;
        @(negedge clk);
        #1;

        // Request dropped mid-load; the next request must start without delay.
        run_load(4'd1, 176, 10, 0, "id1_drop");
        run_load(4'd4, 618, 0, 0, "after_drop");

        // Randomized loads.
        for (int i = 0; i < 12; i++) begin
            fill_random();
            rid   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
            rlat  = ref_latency(int'(rid));
            rdrop = ($urandom_range(0, 1) == 1) ? $urandom_range(1, rlat) : 0;
            run_load(rid, rlat, rdrop, $urandom_range(0, 5), "rand");
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lenet_weight_loader.md
LENET_WEIGHT_LOADER -- requirements
Module: lenet_weight_loader

Interface
REQ-001 SHALL provide parameter WMEM_AW, 16, weight-memory byte-address width.
REQ-002 SHALL provide parameter WBUF_AW, 10, weight-buffer address width (max 900 entries).
REQ-003 SHALL provide ports:
- clk_i, input, 1, single clock, rising edge.
- rst_async_n_i, input, 1, reset, asynchronous, active-low.
- req_load_weight_i, input, 1, load request, level, held until acknowledged.
- layer_id_i, input, 4, layer/group select, sampled with request.
- weight_loaded_o, input-side ack, output, 1, one-cycle done pulse.
- err_layer_o, output, 1, one-cycle pulse with weight_loaded_o when the ID is invalid.
- wmem_rd_en_o, output, 1, weight-memory read strobe.
- wmem_addr_o, output, WMEM_AW, weight-memory byte address.
- wmem_rdata_i, input, 8, read data, valid exactly 1 cycle after the strobe.
- wbuf_we_o, output, 1, weight-buffer write.
- wbuf_addr_o, output, WBUF_AW, weight index, 0-based.
- wbuf_wdata_o, output, 8, weight byte.
- bias_we_o, output, 1, bias-register write.
- bias_addr_o, output, 3, output-channel index.
- bias_wdata_o, output, 32, assembled bias.

Function
REQ-004 SHALL use a layer table of {weight base, Nw, bias base, Nb}:
- ID1: 0x0000, 150, 0x0100, 6.
- ID2: 0x0200, 900, 0x0600, 6.
- ID3: 0x0700, 900, 0x0B00, 6.
- ID4: 0x0C00, 600, 0x0F00, 4.
REQ-005 SHALL treat any other layer_id_i as invalid.
REQ-006 SHALL implement the states IDLE, FETCH_W, FETCH_B, DRAIN, DONE and WAIT_RELEASE.
REQ-007 IDLE: when req_load_weight_i=1 is sampled, SHALL latch layer_id_i and go to FETCH_W; an invalid ID goes directly to DONE.
REQ-008 FETCH_W: SHALL assert wmem_rd_en_o every cycle with address = weight base + k, for k = 0..Nw-1; after the last read SHALL go to FETCH_B.
REQ-009 FETCH_B: SHALL assert wmem_rd_en_o every cycle with address = bias base + j, for j = 0..4·Nb-1; after the last read SHALL go to DRAIN.
REQ-010 Every read response SHALL be written exactly 1 cycle after its strobe; the pipeline overlaps across the FETCH_W/FETCH_B boundary.
- Weight k: wbuf_we_o=1, wbuf_addr_o=k, wbuf_wdata_o=byte.
REQ-011 Bias bytes SHALL be assembled little-endian: byte 4c+i lands in bits [8i+7:8i].
- bias_we_o SHALL pulse once per channel c, in the cycle the 4th byte arrives.
- bias_addr_o=c during that pulse.
REQ-012 DRAIN SHALL last 1 cycle, performing the final bias write, then go to DONE.
REQ-013 DONE SHALL last 1 cycle with weight_loaded_o=1, then go to WAIT_RELEASE.
REQ-014 Valid-ID latency: weight_loaded_o SHALL be high in cycle Nw+4·Nb+2 after the sampling edge (ID1: 176).
REQ-015 Invalid-ID latency: weight_loaded_o and err_layer_o SHALL be high in cycle 1; no memory or buffer activity.
REQ-016 WAIT_RELEASE SHALL return to IDLE only once req_load_weight_i=0 is sampled, so a held request never triggers a second load.
REQ-017 If the request drops mid-load, the load SHALL complete normally; DONE pulses, then WAIT_RELEASE exits on the next edge.
REQ-018 layer_id_i changes after sampling SHALL be ignored.
REQ-019 Counters SHALL be sized to the table without wrap: weight counter ≥10 bits, bias byte counter ≥5 bits.
REQ-020 Address arithmetic SHALL be unsigned WMEM_AW bits.
REQ-021 All strobes SHALL be 0 outside their states.

Reset
REQ-022 Asserting rst_async_n_i SHALL immediately force state to IDLE and all outputs and counters to 0, including mid-load; the partial load is abandoned.
REQ-023 After reset release, a still-high request SHALL start a fresh load.

Structure
REQ-024 lenet_pkg SHALL hold:
- the state enum;
- the layer-table constants (bases, Nw, Nb);
- the ID encodings 1–4, shared with the sequencing controller.
REQ-025 The block SHALL be a single module with no sub-module; the bias assembler is an internal shift register.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- ID1 request held until ack, memory = address-LSB pattern -> 150 weight writes (addr k, data k[7:0] of 0x0000+k), 6 bias writes (bias0 = 0x03020100 from 0x0100..0x0103), weight_loaded_o in cycle 176, exactly once.
- IDs 2, 3, 4 back-to-back, request dropped 1 cycle after each ack -> acks at cycles 926, 926, 618; last bias_addr_o = 5, 5, 3.
- ID 0 and ID 7 -> weight_loaded_o and err_layer_o in cycle 1, zero reads and zero writes.
- Request held 20 cycles past the ack -> no second load; drop then re-raise -> a new load starts.
- Reset asserted at cycle 80 of an ID2 load -> all outputs 0 within the reset; a new ID2 load after release completes with correct data.
- Request dropped at cycle 10 of an ID1 load -> load completes, ack in cycle 176, state returns to IDLE.
